// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the tic-tac-toe match logic: board width, the
// match-state encoding seen by the game manager and display path, the eight
// winning line masks, and helpers to detect a line and count occupied cells.
// Grid bit index = 3*row + col.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int GRID_W = 9;

    typedef enum logic [2:0] {
        P1_TURN = 3'd0,
        P2_TURN = 3'd1,
        P1_WIN  = 3'd2,
        P2_WIN  = 3'd3,
        DRAW    = 3'd4
    } game_state_t;

    // Rows, columns, then the two diagonals.
    localparam logic [7:0][GRID_W-1:0] WIN_MASKS = {
        9'h054, 9'h111,
        9'h124, 9'h092, 9'h049,
        9'h1C0, 9'h038, 9'h007
    };

    // True when every cell of at least one line is held in this grid.
    function automatic logic has_line(input logic [GRID_W-1:0] grid);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((grid & WIN_MASKS[i]) == WIN_MASKS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Number of occupied cells in a grid (0..9).
    function automatic logic [3:0] popcount9(input logic [GRID_W-1:0] grid);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < GRID_W; i++) begin
            n = n + {3'b000, grid[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/game_status_if.sv
// ---------------------------------------------------------------------------
// game_status_if
// Bundles the game-manager side signals of game_status.
//   btns_gs      raw centre button (asynchronous, bouncy)
//   p1Grid_gs    player 1 occupancy grid
//   p2Grid_gs    player 2 occupancy grid
//   gameState_gs registered match state (game_pkg encoding)
// master = game manager / driver, slave = game_status.
// ---------------------------------------------------------------------------
interface game_status_if;
    import game_pkg::*;

    logic              btns_gs;
    logic [GRID_W-1:0] p1Grid_gs;
    logic [GRID_W-1:0] p2Grid_gs;
    logic [2:0]        gameState_gs;

    modport master (
        output btns_gs,
        output p1Grid_gs,
        output p2Grid_gs,
        input  gameState_gs
    );

    modport slave (
        input  btns_gs,
        input  p1Grid_gs,
        input  p2Grid_gs,
        output gameState_gs
    );

endinterface

// File: rtl/debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
// Two-flop synchronizer followed by a consecutive-mismatch counter. The
// debounced level only follows the synchronized input once they have
// disagreed for DEBOUNCE_CYCLES clocks in a row; any agreement restarts the
// count, so short glitches never reach the output.
// Ports:
//   clk      system clock (rising edge)
//   rst      synchronous active-high reset
//   btn_raw  asynchronous raw button
//   db       debounced level
// ---------------------------------------------------------------------------
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // The flip happens on the clock where the count is already at its last
    // value and the mismatch persists, giving exactly DEBOUNCE_CYCLES
    // mismatching clocks before the level changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                db    <= sync2;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_status.sv
// ---------------------------------------------------------------------------
// game_status
// Tracks whose turn it is and whether the match has ended. Each debounced
// press of the centre button re-evaluates the grid of the player to move: a
// move is accepted only if that player's cell count grew since the last
// accepted move, after which a line wins, a full board draws, and otherwise
// the turn passes. Win and draw states hold until reset.
// Ports:
//   clk_gs  system clock (rising edge)
//   rst_gs  synchronous active-high reset
//   gs      game_status_if.slave: btns_gs, p1Grid_gs, p2Grid_gs in,
//           gameState_gs out (registered)
// ---------------------------------------------------------------------------
module game_status
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk_gs,
    input  logic         rst_gs,
    game_status_if.slave gs
);

    logic        db;
    logic        db_d;
    logic        press;
    logic        board_full;
    logic [3:0]  pop1;
    logic [3:0]  pop2;
    logic [3:0]  cnt1;
    logic [3:0]  cnt2;
    game_state_t state;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk_gs),
        .rst     (rst_gs),
        .btn_raw (gs.btns_gs),
        .db      (db)
    );

    // One-cycle pulse on the rising edge of the debounced level only.
    assign press      = db & ~db_d;
    assign pop1       = popcount9(gs.p1Grid_gs);
    assign pop2       = popcount9(gs.p2Grid_gs);
    assign board_full = ((gs.p1Grid_gs | gs.p2Grid_gs) == 9'h1FF);

    // cnt1/cnt2 remember each player's cell count at their last accepted
    // move, so a press without a new mark (e.g. on an occupied cell) is
    // rejected and the same player keeps the turn. A line is checked before
    // the full board so a winning final move is never scored as a draw.
    always_ff @(posedge clk_gs) begin
        if (rst_gs) begin
            state <= P1_TURN;
            cnt1  <= '0;
            cnt2  <= '0;
            db_d  <= 1'b0;
        end else begin
            db_d <= db;
            if (press) begin
                case (state)
                    P1_TURN: begin
                        if (pop1 > cnt1) begin
                            cnt1 <= pop1;
                            if (has_line(gs.p1Grid_gs)) begin
                                state <= P1_WIN;
                            end else if (board_full) begin
                                state <= DRAW;
                            end else begin
                                state <= P2_TURN;
                            end
                        end
                    end
                    P2_TURN: begin
                        if (pop2 > cnt2) begin
                            cnt2 <= pop2;
                            if (has_line(gs.p2Grid_gs)) begin
                                state <= P2_WIN;
                            end else if (board_full) begin
                                state <= DRAW;
                            end else begin
                                state <= P1_TURN;
                            end
                        end
                    end
                    P1_WIN, P2_WIN, DRAW: begin
                        state <= state;
                    end
                    default: begin
                        state <= P1_TURN;
                    end
                endcase
            end
        end
    end

    assign gs.gameState_gs = state;

endmodule

// File: tb/tb_game_status.sv
// ---------------------------------------------------------------------------
// tb_game_status
// Drives game_status (debounce length 4) with directed games and a random
// phase of bouncy presses, legal and rejected moves and stray resets. A
// reference model derives the expected match state from the game rules.
// ---------------------------------------------------------------------------
module tb_game_status;

    localparam int N = 4;

    logic clk_gs;
    logic rst_gs;
    int   total;
    int   bad;
    bit   check_en;

    game_status_if gs_if ();

    game_status #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk_gs (clk_gs),
        .rst_gs (rst_gs),
        .gs     (gs_if)
    );

    initial clk_gs = 1'b0;
    always #5 clk_gs = ~clk_gs;

    // ---------------- reference model ----------------
    // Raw samples of the button, newest in bit 0; the debounced level flips
    // when the N samples seen two clocks ago and earlier all disagree with it.
    logic [7:0]   smp;
    logic         m_db;
    logic         m_pend;
    int           m_state;
    int           m_c1;
    int           m_c2;

    function automatic int cells(input logic [8:0] g);
        int n = 0;
        for (int i = 0; i < 9; i++) if (g[i]) n++;
        return n;
    endfunction

    function automatic bit wins(input logic [8:0] g);
        for (int r = 0; r < 3; r++) if (g[3*r] && g[3*r+1] && g[3*r+2]) return 1'b1;
        for (int c = 0; c < 3; c++) if (g[c] && g[c+3] && g[c+6]) return 1'b1;
        if (g[0] && g[4] && g[8]) return 1'b1;
        if (g[2] && g[4] && g[6]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int outcome(input logic [8:0] mine, input logic [8:0] other,
                                   input int win_code, input int next_turn);
        if (wins(mine)) return win_code;
        if ((mine | other) == 9'h1FF) return 4;
        return next_turn;
    endfunction

    function automatic bit all_differ(input logic [N-1:0] w, input logic lvl);
        return lvl ? (w == '0) : (w == '1);
    endfunction

    // Model state advances on the same rising edge as the design; inputs
    // only change on falling edges.
    always @(posedge clk_gs) begin
        if (rst_gs) begin
            smp     <= '0;
            m_db    <= 1'b0;
            m_pend  <= 1'b0;
            m_state <= 0;
            m_c1    <= 0;
            m_c2    <= 0;
        end else begin
            smp <= {smp[6:0], gs_if.btns_gs};
            if (all_differ(smp[N:1], m_db)) begin
                m_db   <= ~m_db;
                m_pend <= ~m_db;
            end else begin
                m_pend <= 1'b0;
            end
            if (m_pend) begin
                if (m_state == 0 && cells(gs_if.p1Grid_gs) > m_c1) begin
                    m_c1    <= cells(gs_if.p1Grid_gs);
                    m_state <= outcome(gs_if.p1Grid_gs, gs_if.p2Grid_gs, 2, 1);
                end else if (m_state == 1 && cells(gs_if.p2Grid_gs) > m_c2) begin
                    m_c2    <= cells(gs_if.p2Grid_gs);
                    m_state <= outcome(gs_if.p2Grid_gs, gs_if.p1Grid_gs, 3, 0);
                end
            end
        end
    end

    // ---------------- bench tasks ----------------
    // Advance to the next falling edge and compare the output with the model.
    task automatic tick();
        @(negedge clk_gs);
        if (check_en) begin
            total++;
            if (gs_if.gameState_gs !== 3'(m_state)) begin
                bad++;
                $display("[TB] FAIL model_cmp t=%0t got=%0d want=%0d",
                         $time, gs_if.gameState_gs, m_state);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expected);
        total++;
        if (gs_if.gameState_gs !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, gs_if.gameState_gs, expected);
        end
    endtask

    // Optional short glitches, a stable high of 'hold' clocks, then release.
    task automatic applyStimulus(input int glitches, input int hold);
        for (int b = 0; b < glitches; b++) begin
            gs_if.btns_gs = 1'b1;
            repeat ($urandom_range(1, N - 1)) tick();
            gs_if.btns_gs = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        gs_if.btns_gs = 1'b1;
        repeat (hold) tick();
        gs_if.btns_gs = 1'b0;
        repeat (N + 6) tick();
    endtask

    task automatic doReset();
        rst_gs = 1'b1;
        gs_if.p1Grid_gs = '0;
        gs_if.p2Grid_gs = '0;
        tick();
        tick();
        rst_gs = 1'b0;
    endtask

    logic [8:0] p1_seq [5];
    logic [8:0] p2_seq [4];

    initial begin
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        rst_gs   = 1'b1;
        gs_if.btns_gs   = 1'b0;
        gs_if.p1Grid_gs = '0;
        gs_if.p2Grid_gs = '0;
        repeat (3) @(negedge clk_gs);
        rst_gs   = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_state", 3'd0);
        repeat (8) tick();
        checkOutput("idle_low", 3'd0);

        // Bouncy press: 2-clock glitches then a stable high; state moves on edge 7.
        gs_if.p1Grid_gs = 9'h001;
        repeat (3) begin
            gs_if.btns_gs = 1'b1; tick(); tick();
            gs_if.btns_gs = 1'b0; tick(); tick();
        end
        gs_if.btns_gs = 1'b1;
        repeat (6) tick();
        checkOutput("before_edge7", 3'd0);
        tick();
        checkOutput("at_edge7", 3'd1);
        repeat (9) tick();
        gs_if.btns_gs = 1'b0;
        repeat (N + 6) tick();
        checkOutput("held_one_press", 3'd1);

        // Rejected press, then a real P2 move.
        applyStimulus(0, N + 4);
        checkOutput("rejected_move", 3'd1);
        gs_if.p2Grid_gs = 9'h010;
        applyStimulus(0, N + 4);
        checkOutput("p2_move", 3'd0);

        // Row 0 win for P1, sticky, cleared by reset.
        gs_if.p1Grid_gs = 9'h003; applyStimulus(1, N + 4);
        gs_if.p2Grid_gs = 9'h030; applyStimulus(1, N + 4);
        gs_if.p1Grid_gs = 9'h007; applyStimulus(0, N + 4);
        checkOutput("row_win", 3'd2);
        applyStimulus(0, N + 4);
        checkOutput("win_sticky", 3'd2);
        doReset();
        checkOutput("after_reset", 3'd0);

        // Diagonal {2,4,6} win for P2.
        gs_if.p1Grid_gs = 9'h001; applyStimulus(0, N + 4);
        gs_if.p2Grid_gs = 9'h004; applyStimulus(0, N + 4);
        gs_if.p1Grid_gs = 9'h003; applyStimulus(0, N + 4);
        gs_if.p2Grid_gs = 9'h014; applyStimulus(0, N + 4);
        gs_if.p1Grid_gs = 9'h00B; applyStimulus(0, N + 4);
        gs_if.p2Grid_gs = 9'h054; applyStimulus(0, N + 4);
        checkOutput("diag_win", 3'd3);
        doReset();

        // Full board with no line: draw.
        p1_seq = '{9'h001, 9'h005, 9'h015, 9'h035, 9'h0B5};
        p2_seq = '{9'h002, 9'h00A, 9'h04A, 9'h14A};
        for (int i = 0; i < 5; i++) begin
            gs_if.p1Grid_gs = p1_seq[i]; applyStimulus(0, N + 4);
            if (i < 4) begin
                gs_if.p2Grid_gs = p2_seq[i]; applyStimulus(0, N + 4);
            end
        end
        checkOutput("draw", 3'd4);
        doReset();

        // Full board whose last move completes {0,4,8}: the win wins.
        p1_seq = '{9'h001, 9'h003, 9'h013, 9'h033, 9'h133};
        p2_seq = '{9'h004, 9'h00C, 9'h04C, 9'h0CC};
        for (int i = 0; i < 5; i++) begin
            gs_if.p1Grid_gs = p1_seq[i]; applyStimulus(0, N + 4);
            if (i < 4) begin
                gs_if.p2Grid_gs = p2_seq[i]; applyStimulus(0, N + 4);
            end
        end
        checkOutput("win_priority", 3'd2);
        doReset();

        // Random play: legal and rejected moves, bounces, short holds,
        // and occasional resets in the middle of a debounce.
        for (int g = 0; g < 200; g++) begin
            if (m_state >= 2 || $urandom_range(0, 24) == 0) begin
                doReset();
            end else begin
                if ($urandom_range(0, 9) < 8) begin
                    logic [8:0] freeCells;
                    int pick;
                    freeCells = ~(gs_if.p1Grid_gs | gs_if.p2Grid_gs);
                    if (freeCells != '0) begin
                        pick = $urandom_range(0, 8);
                        while (!freeCells[pick]) pick = (pick + 1) % 9;
                        if (m_state == 0) gs_if.p1Grid_gs[pick] = 1'b1;
                        else              gs_if.p2Grid_gs[pick] = 1'b1;
                    end
                end
                if ($urandom_range(0, 14) == 0) begin
                    gs_if.btns_gs = 1'b1;
                    repeat ($urandom_range(1, N + 3)) tick();
                    rst_gs = 1'b1;
                    tick();
                    rst_gs = 1'b0;
                    gs_if.btns_gs = 1'b0;
                    repeat (N + 6) tick();
                end else begin
                    applyStimulus($urandom_range(0, 3), $urandom_range(N - 1, N + 8));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
